// File: rtl/md_wb_buffer.sv
// rtl/md_wb_buffer.sv - multiplier writeback tracker with an in-order result FIFO
// Tracks the single MUL* op in flight, tags its result with rd and queues it for writeback.
module md_wb_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int RD_W  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [RD_W-1:0]              issue_rd,
    output logic                         issue_ready,
    input  logic                         md_alu_done,
    input  logic [XLEN-1:0]              md_result,
    input  logic                         flush,
    output logic                         wb_valid,
    output logic [RD_W-1:0]              wb_rd,
    output logic [XLEN-1:0]              wb_data,
    input  logic                         wb_ready,
    output logic                         inflight,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_spurious
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        KILLED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RD_W-1:0]        r_rd;
    logic [RD_W-1:0]        r_mem_rd   [DEPTH];
    logic [XLEN-1:0]        r_mem_data [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_nxt = flush ? KILLED : BUSY;
                end
            end
            BUSY: begin
                if (md_alu_done) begin
                    w_state_nxt = IDLE;
                end else if (flush) begin
                    w_state_nxt = KILLED;
                end
            end
            KILLED: begin
                if (md_alu_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A free slot is reserved at issue, so a completing op can always be pushed.
    always_comb begin
        w_full      = (r_count == CNT_W'(DEPTH));
        inflight    = (r_state != IDLE);
        issue_ready = (r_state == IDLE) && (r_count < CNT_W'(DEPTH));
        w_issue     = issue_valid && issue_ready;
        w_push      = (r_state == BUSY) && md_alu_done && !flush && (r_rd != '0);
        w_pop       = (r_count != '0) && wb_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_issue) begin
                r_rd <= issue_rd;
            end
            if (r_state == IDLE && md_alu_done) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_rd[i]   <= '0;
                r_mem_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_rd[r_wr_ptr]   <= r_rd;
                r_mem_data[r_wr_ptr] <= md_result;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (!(w_push && w_full)) else $error("md_wb_buffer: push into full result FIFO");
        end
    end

    assign wb_valid     = (r_count != '0);
    assign wb_rd        = r_mem_rd[r_rd_ptr];
    assign wb_data      = r_mem_data[r_rd_ptr];
    assign count        = r_count;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_md_wb_buffer.sv
// tb/tb_md_wb_buffer.sv - scoreboard testbench for md_wb_buffer
module tb_md_wb_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        md_alu_done;
    logic [31:0] md_result;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        inflight;
    logic [1:0]  count;
    logic        err_spurious;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] sb[$];

    md_wb_buffer #(.DEPTH(2), .XLEN(32), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .md_alu_done(md_alu_done), .md_result(md_result), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .inflight(inflight), .count(count), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted writeback handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && wb_valid && wb_ready) begin
            logic [36:0] exp_e;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got rd=%0d data=%h, required no output", wb_rd, wb_data);
            end else begin
                exp_e = sb.pop_front();
                if ({wb_rd, wb_data} !== exp_e)
                    $display("FAIL sb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_rd, wb_data, exp_e[36:32], exp_e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // flush_at: -1 none, 0 issue cycle, k cycles after issue, 17 done cycle.
    // Returns just after the done edge; pre_inflight is sampled in the cycle before done.
    task automatic do_op(input logic [4:0] rd, input logic [31:0] data, input int flush_at,
                         output logic pre_inflight);
        issue_valid = 1'b1;
        issue_rd    = rd;
        flush       = (flush_at == 0);
        cyc();
        issue_valid = 1'b0;
        for (int k = 1; k < 17; k++) begin
            flush = (flush_at == k);
            cyc();
        end
        flush        = (flush_at == 17);
        pre_inflight = inflight;
        md_alu_done  = 1'b1;
        md_result    = data;
        if (flush_at < 0 && rd != 5'd0) sb.push_back({rd, data});
        cyc();
        md_alu_done = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        n_checks++;
        if ({wb_valid, wb_rd, wb_data, count, inflight, err_spurious, issue_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: got v=%b rd=%0d d=%h cnt=%0d inf=%b err=%b rdy=%b, required 0/0/0/0/0/0/1",
                     wb_valid, wb_rd, wb_data, count, inflight, err_spurious, issue_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        logic pi;
        wb_ready = 1'b1;
        do_op(5'd5, 32'h0000_000C, -1, pi);
        n_checks++;
        if (pi !== 1'b1) $display("FAIL single_inflight: got %b, required 1", pi); else n_pass++;
        n_checks++;
        if ({wb_valid, wb_rd, wb_data, issue_ready, inflight} !== {1'b1, 5'd5, 32'hC, 1'b1, 1'b0})
            $display("FAIL single_out: got v=%b rd=%0d d=%h rdy=%b inf=%b, required 1/5/c/1/0",
                     wb_valid, wb_rd, wb_data, issue_ready, inflight);
        else n_pass++;
        cyc(2);
        n_checks++;
        if (count !== 2'd0) $display("FAIL single_drain: got count=%0d, required 0", count); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic pi;
        wb_ready = 1'b0;
        do_op(5'd1, 32'h11, -1, pi);
        cyc(2);
        do_op(5'd2, 32'h22, -1, pi);
        n_checks++;
        if ({count, issue_ready} !== {2'd2, 1'b0})
            $display("FAIL bp_full: got count=%0d rdy=%b, required 2/0", count, issue_ready);
        else n_pass++;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        cyc();
        issue_valid = 1'b0;
        n_checks++;
        if ({inflight, wb_rd, wb_data} !== {1'b0, 5'd1, 32'h11})
            $display("FAIL bp_ignore_head: got inf=%b rd=%0d d=%h, required 0/1/11", inflight, wb_rd, wb_data);
        else n_pass++;
        wb_ready = 1'b1;
        cyc();
        n_checks++;
        if ({wb_valid, wb_rd, wb_data, count} !== {1'b1, 5'd2, 32'h22, 2'd1})
            $display("FAIL bp_second: got v=%b rd=%0d d=%h cnt=%0d, required 1/2/22/1", wb_valid, wb_rd, wb_data, count);
        else n_pass++;
        cyc();
        n_checks++;
        if ({wb_valid, count} !== {1'b0, 2'd0})
            $display("FAIL bp_empty: got v=%b cnt=%0d, required 0/0", wb_valid, count);
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_rd_zero();
        logic pi;
        do_op(5'd0, 32'hDEAD, -1, pi);
        n_checks++;
        if ({wb_valid, count, inflight, pi} !== {1'b0, 2'd0, 1'b0, 1'b1})
            $display("FAIL rd_zero: got v=%b cnt=%0d inf=%b pre=%b, required 0/0/0/1", wb_valid, count, inflight, pi);
        else n_pass++;
        cyc(2);
    endtask

    task automatic test_flush();
        logic pi;
        int   fpos[3] = '{5, 17, 0};
        for (int i = 0; i < 3; i++) begin
            do_op(5'd7, 32'h700 + i, fpos[i], pi);
            n_checks++;
            if ({wb_valid, count, inflight, pi} !== {1'b0, 2'd0, 1'b0, 1'b1})
                $display("FAIL flush_%0d: got v=%b cnt=%0d inf=%b pre=%b, required 0/0/0/1",
                         fpos[i], wb_valid, count, inflight, pi);
            else n_pass++;
            cyc(2);
        end
    endtask

    task automatic test_spurious();
        n_checks++;
        if (err_spurious !== 1'b0) $display("FAIL spur_pre: got %b, required 0", err_spurious); else n_pass++;
        md_alu_done = 1'b1;
        md_result   = 32'hBAD;
        cyc();
        md_alu_done = 1'b0;
        cyc(3);
        n_checks++;
        if ({err_spurious, count, wb_valid, inflight} !== {1'b1, 2'd0, 1'b0, 1'b0})
            $display("FAIL spur_set: got err=%b cnt=%0d v=%b inf=%b, required 1/0/0/0", err_spurious, count, wb_valid, inflight);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic pi;
        wb_ready = 1'b0;
        do_op(5'd3, 32'h33, -1, pi);
        cyc(2);
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        cyc();
        issue_valid = 1'b0;
        n_checks++;
        if ({count, inflight} !== {2'd1, 1'b1})
            $display("FAIL mid_setup: got cnt=%0d inf=%b, required 1/1", count, inflight);
        else n_pass++;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        sb.delete();
        n_checks++;
        if ({wb_valid, wb_rd, wb_data, count, inflight, err_spurious, issue_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL mid_reset: got v=%b rd=%0d d=%h cnt=%0d inf=%b err=%b rdy=%b, required 0/0/0/0/0/0/1",
                     wb_valid, wb_rd, wb_data, count, inflight, err_spurious, issue_ready);
        else n_pass++;
        cyc(5);
        md_alu_done = 1'b1;
        md_result   = 32'h44;
        cyc();
        md_alu_done = 1'b0;
        n_checks++;
        if ({err_spurious, count} !== {1'b1, 2'd0})
            $display("FAIL mid_late_done: got err=%b cnt=%0d, required 1/0", err_spurious, count);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; md_alu_done = 1'b0;
        md_result = '0; flush = 1'b0; wb_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_rd_zero();
        test_flush();
        test_spurious();
        test_reset_midop();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries, required 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
